mult_wb_buffer: RTL and testbench

//  Writeback buffer directly downstream of the mult/div functional unit. The multiplier path has
//  no backpressure, so this block absorbs every result (result, trans_id) into a DEPTH-entry FIFO
//  and presents it to the writeback/scoreboard port with a valid/ready handshake. It also issues

---
 rtl/mult_wb_buffer_pkg.sv | 16 +
 rtl/mult_wb_buffer_fifo.sv | 64 ++++++
 rtl/mult_wb_buffer.sv | 143 ++++++++++++++
 tb/tb_mult_wb_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_wb_buffer_pkg.sv
// Shared types for the mult/div writeback buffer: trans-id width, FIFO entry, FSM states.
package mult_wb_buffer_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [63:0]              result;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } mult_wb_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } wb_state_e;

endpackage

// File: rtl/mult_wb_buffer_fifo.sv
// DEPTH-entry FIFO of writeback entries; clear empties it in one cycle.
module mult_wb_fifo
  import mult_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  mult_wb_entry_t   push_data,
  input  logic             pop,
  output mult_wb_entry_t   head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  mult_wb_entry_t   mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mult_wb_buffer.sv
// Writeback buffer behind the mult/div unit: result FIFO, issue credits and post-flush drop window.
// Optional same-cycle bypass to writeback when the FIFO is empty: define MULT_WB_BYPASS_EN.
module mult_wb_buffer
  import mult_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned MUL_LATENCY = 2,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_fire_i,
  output logic                     issue_ready_o,
  input  logic                     mult_valid_i,
  input  logic [DATA_WIDTH-1:0]    mult_result_i,
  input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [DATA_WIDTH-1:0]    wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [CNT_W-1:0]         count_o,
  output logic                     error_o
);

  localparam int unsigned DROP_W = $clog2(MUL_LATENCY + 1);

  wb_state_e        state_r, state_s;
  logic [DROP_W-1:0] drop_cnt_r, drop_cnt_s;
  logic [CNT_W-1:0]  inflight_r, inflight_s;
  logic              error_r, error_s;

  mult_wb_entry_t   push_entry_s;
  mult_wb_entry_t   head_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             clear_s;
  logic             accept_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;
  logic             dec_s;
  logic             sat_s;
  logic             unexpected_s;
  logic             overflow_s;

  // A result is taken only in RUN and not in a flush cycle; everything else is silently dropped.
  assign accept_s = (state_r == RUN) && !flush_i && mult_valid_i;

`ifdef MULT_WB_BYPASS_EN
  assign bypass_s = accept_s && fifo_empty_s;
`else
  assign bypass_s = 1'b0;
`endif

  assign wb_valid_o    = bypass_s || ((state_r == RUN) && !fifo_empty_s);
  assign wb_result_o   = bypass_s ? mult_result_i : head_s.result;
  assign wb_trans_id_o = bypass_s ? mult_trans_id_i : head_s.trans_id;
  assign pop_s         = wb_valid_o && wb_ready_i && !bypass_s;
  assign push_s        = accept_s && !(bypass_s && wb_ready_i);

  assign push_entry_s.result   = mult_result_i;
  assign push_entry_s.trans_id = mult_trans_id_i;

  assign dec_s        = accept_s && (inflight_r != '0);
  assign unexpected_s = accept_s && (inflight_r == '0);
  assign sat_s        = (state_r == RUN) && !flush_i && issue_fire_i && !dec_s
                        && (inflight_r == CNT_W'(DEPTH));
  assign overflow_s   = push_s && fifo_full_s && !pop_s;
  assign error_s      = error_r || overflow_s || unexpected_s || sat_s;

  assign issue_ready_o = (state_r == RUN)
                         && (({1'b0, fifo_count_s} + {1'b0, inflight_r}) < (CNT_W + 1)'(DEPTH));
  assign count_o       = fifo_count_s;
  assign error_o       = error_r;

  mult_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .clear     (clear_s),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Next-state, drop window and in-flight credit tracking.
  always_comb begin
    state_s    = state_r;
    drop_cnt_s = drop_cnt_r;
    inflight_s = inflight_r;
    clear_s    = 1'b0;
    case (state_r)
      RUN: begin
        if (flush_i) begin
          state_s    = DRAIN;
          drop_cnt_s = DROP_W'(MUL_LATENCY);
          inflight_s = '0;
          clear_s    = 1'b1;
        end else begin
          case ({issue_fire_i, dec_s})
            2'b10:   inflight_s = sat_s ? inflight_r : inflight_r + CNT_W'(1);
            2'b01:   inflight_s = inflight_r - CNT_W'(1);
            default: inflight_s = inflight_r;
          endcase
        end
      end
      DRAIN: begin
        if (flush_i) begin
          drop_cnt_s = DROP_W'(MUL_LATENCY);
        end else if (drop_cnt_r <= DROP_W'(1)) begin
          state_s = RUN;
        end else begin
          drop_cnt_s = drop_cnt_r - DROP_W'(1);
        end
      end
      default: state_s = RUN;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= RUN;
      drop_cnt_r <= '0;
      inflight_r <= '0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      drop_cnt_r <= drop_cnt_s;
      inflight_r <= inflight_s;
      error_r    <= error_s;
    end
  end

endmodule

// File: tb/tb_mult_wb_buffer.sv
// Directed self-checking bench for mult_wb_buffer: vector table plus multi-cycle corner sequences.
module tb_mult_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        issue_fire_i;
  logic        issue_ready_o;
  logic        mult_valid_i;
  logic [63:0] mult_result_i;
  logic [2:0]  mult_trans_id_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [63:0] wb_result_o;
  logic [2:0]  wb_trans_id_o;
  logic [2:0]  count_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  mult_wb_buffer #(
    .DEPTH       (4),
    .DATA_WIDTH  (64),
    .MUL_LATENCY (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .issue_fire_i    (issue_fire_i),
    .issue_ready_o   (issue_ready_o),
    .mult_valid_i    (mult_valid_i),
    .mult_result_i   (mult_result_i),
    .mult_trans_id_i (mult_trans_id_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_result_o     (wb_result_o),
    .wb_trans_id_o   (wb_trans_id_o),
    .count_o         (count_o),
    .error_o         (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        fire;
    logic        mv;
    logic [63:0] res;
    logic [2:0]  id;
    logic        rdy;
    logic        e_ir;
    logic        e_wv;
    logic [63:0] e_res;
    logic [2:0]  e_id;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge; outputs are checked right after.
  task automatic drive(input logic fire, input logic mv, input logic [63:0] res,
                       input logic [2:0] id, input logic fl, input logic rdy);
    @(negedge clk_i);
    issue_fire_i    = fire;
    mult_valid_i    = mv;
    mult_result_i   = res;
    mult_trans_id_i = id;
    flush_i         = fl;
    wb_ready_i      = rdy;
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 64'h0, 3'd0, 1'b0, rdy);
  endtask

  initial begin
    logic [63:0] exp_res [4];
    logic [2:0]  exp_id  [4];

    rst_ni = 1'b0; flush_i = 1'b0; issue_fire_i = 1'b0; mult_valid_i = 1'b0;
    mult_result_i = 64'h0; mult_trans_id_i = 3'd0; wb_ready_i = 1'b0;
    #2;
    check("rst_issue_ready", {63'h0, issue_ready_o}, 64'h1);
    check("rst_wb_valid",    {63'h0, wb_valid_o},    64'h0);
    check("rst_count",       {61'h0, count_o},       64'h0);
    check("rst_error",       {63'h0, error_o},       64'h0);
    check("rst_wb_result",   wb_result_o,            64'h0);
    check("rst_wb_id",       {61'h0, wb_trans_id_o}, 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill four entries under backpressure, then drain in order.
    vecs[0]  = '{1'b0, 1'b0, 64'h0,  3'd0, 1'b0, 1'b1, 1'b0, 64'h0,  3'd0, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 64'h0,  3'd0, 1'b0, 1'b1, 1'b0, 64'h0,  3'd0, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 64'h0,  3'd0, 1'b0, 1'b1, 1'b0, 64'h0,  3'd0, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 64'h0,  3'd0, 1'b0, 1'b1, 1'b0, 64'h0,  3'd0, 3'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 64'h0,  3'd0, 1'b0, 1'b1, 1'b0, 64'h0,  3'd0, 3'd0, 1'b0};
`ifdef MULT_WB_BYPASS_EN
    vecs[5]  = '{1'b0, 1'b1, 64'h11, 3'd0, 1'b0, 1'b0, 1'b1, 64'h11, 3'd0, 3'd0, 1'b0};
`else
    vecs[5]  = '{1'b0, 1'b1, 64'h11, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0,  3'd0, 3'd0, 1'b0};
`endif
    vecs[6]  = '{1'b0, 1'b1, 64'h22, 3'd1, 1'b0, 1'b0, 1'b1, 64'h11, 3'd0, 3'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 64'h33, 3'd2, 1'b0, 1'b0, 1'b1, 64'h11, 3'd0, 3'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 64'h44, 3'd3, 1'b0, 1'b0, 1'b1, 64'h11, 3'd0, 3'd3, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 64'h0,  3'd0, 1'b0, 1'b0, 1'b1, 64'h11, 3'd0, 3'd4, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 64'h0,  3'd0, 1'b1, 1'b0, 1'b1, 64'h11, 3'd0, 3'd4, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 64'h0,  3'd0, 1'b1, 1'b1, 1'b1, 64'h22, 3'd1, 3'd3, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 64'h0,  3'd0, 1'b1, 1'b1, 1'b1, 64'h33, 3'd2, 3'd2, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 64'h0,  3'd0, 1'b1, 1'b1, 1'b1, 64'h44, 3'd3, 3'd1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 64'h0,  3'd0, 1'b1, 1'b1, 1'b0, 64'h0,  3'd0, 3'd0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].fire, vecs[i].mv, vecs[i].res, vecs[i].id, 1'b0, vecs[i].rdy);
      check($sformatf("vec%0d_issue_ready", i), {63'h0, issue_ready_o}, {63'h0, vecs[i].e_ir});
      check($sformatf("vec%0d_wb_valid", i),    {63'h0, wb_valid_o},    {63'h0, vecs[i].e_wv});
      check($sformatf("vec%0d_count", i),       {61'h0, count_o},       {61'h0, vecs[i].e_cnt});
      check($sformatf("vec%0d_error", i),       {63'h0, error_o},       {63'h0, vecs[i].e_err});
      if (vecs[i].e_wv) begin
        check($sformatf("vec%0d_wb_result", i), wb_result_o,            vecs[i].e_res);
        check($sformatf("vec%0d_wb_id", i),     {61'h0, wb_trans_id_o}, {61'h0, vecs[i].e_id});
      end
    end

    // Full FIFO: simultaneous pop and push keeps count at 4; 0xAA comes out last.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 64'h11 * (i + 1), 3'(i), 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
    check("full_count", {61'h0, count_o}, 64'h4);
    drive(1'b0, 1'b1, 64'hAA, 3'd5, 1'b0, 1'b1);
    check("pp_head", wb_result_o, 64'h11);
    exp_res = '{64'h22, 64'h33, 64'h44, 64'hAA};
    exp_id  = '{3'd1, 3'd2, 3'd3, 3'd5};
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      if (k == 0) check("pp_count", {61'h0, count_o}, 64'h4);
      check($sformatf("pp_res%0d", k), wb_result_o,            exp_res[k]);
      check($sformatf("pp_id%0d", k),  {61'h0, wb_trans_id_o}, {61'h0, exp_id[k]});
    end
    idle(1'b0);
    check("pp_final_count", {61'h0, count_o}, 64'h0);
    check("pp_error",       {63'h0, error_o}, 64'h0);

    // Flush with two queued and one in flight; late result dropped during the drain window.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 64'h51, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 64'h52, 3'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 64'h0, 3'd0, 1'b1, 1'b0);
    check("fl_pre_count", {61'h0, count_o}, 64'h2);
    drive(1'b0, 1'b1, 64'h53, 3'd2, 1'b0, 1'b0);
    check("fl_count0",    {61'h0, count_o},       64'h0);
    check("fl_ready0",    {63'h0, issue_ready_o}, 64'h0);
    check("fl_valid0",    {63'h0, wb_valid_o},    64'h0);
    idle(1'b0);
    check("fl_ready1",    {63'h0, issue_ready_o}, 64'h0);
    check("fl_count1",    {61'h0, count_o},       64'h0);
    idle(1'b0);
    check("fl_ready2",    {63'h0, issue_ready_o}, 64'h1);
    check("fl_count2",    {61'h0, count_o},       64'h0);
    check("fl_valid2",    {63'h0, wb_valid_o},    64'h0);
    check("fl_error",     {63'h0, error_o},       64'h0);

    // Unexpected result with nothing in flight: stored, error sticky.
    drive(1'b0, 1'b1, 64'h66, 3'd4, 1'b0, 1'b0);
    check("ux_err_pre", {63'h0, error_o}, 64'h0);
    idle(1'b0);
    check("ux_err",   {63'h0, error_o}, 64'h1);
    check("ux_count", {61'h0, count_o}, 64'h1);
    idle(1'b0);
    idle(1'b1);
    check("ux_head",  wb_result_o,      64'h66);
    idle(1'b0);
    check("ux_err_sticky", {63'h0, error_o}, 64'h1);
    check("ux_count0",     {61'h0, count_o}, 64'h0);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 64'h71 + i, 3'(i), 1'b0, 1'b0);
    idle(1'b0);
    check("ar_pre_count", {61'h0, count_o}, 64'h3);
    rst_ni = 1'b0;
    #1;
    check("ar_valid", {63'h0, wb_valid_o},    64'h0);
    check("ar_count", {61'h0, count_o},       64'h0);
    check("ar_ready", {63'h0, issue_ready_o}, 64'h1);
    check("ar_error", {63'h0, error_o},       64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Empty FIFO with ready consumer: bypass latency versus registered path.
    drive(1'b1, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 64'hDEAD, 3'd7, 1'b0, 1'b1);
`ifdef MULT_WB_BYPASS_EN
    check("bp_valid", {63'h0, wb_valid_o},    64'h1);
    check("bp_res",   wb_result_o,            64'hDEAD);
    check("bp_id",    {61'h0, wb_trans_id_o}, 64'h7);
    check("bp_count", {61'h0, count_o},       64'h0);
    idle(1'b1);
    check("bp_next_valid", {63'h0, wb_valid_o}, 64'h0);
    check("bp_next_count", {61'h0, count_o},    64'h0);
`else
    check("bp_valid", {63'h0, wb_valid_o}, 64'h0);
    idle(1'b1);
    check("bp_next_valid", {63'h0, wb_valid_o},    64'h1);
    check("bp_next_res",   wb_result_o,            64'hDEAD);
    check("bp_next_id",    {61'h0, wb_trans_id_o}, 64'h7);
    check("bp_next_count", {61'h0, count_o},       64'h1);
`endif
    idle(1'b1);
    check("bp_end_valid", {63'h0, wb_valid_o}, 64'h0);
    check("bp_end_count", {61'h0, count_o},    64'h0);
    check("bp_end_error", {63'h0, error_o},    64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
